// File: rtl/uart_timing_pkg.sv
// Shared definitions for the echo round-trip timing controller: state
// encodings, report frame layout and default probe/timeout settings.
package uart_timing_pkg;

    localparam logic [7:0] DEFAULT_HDR_BYTE       = 8'hA5;
    localparam logic [7:0] DEFAULT_PROBE_BYTE     = 8'h56;
    localparam int         DEFAULT_TIMEOUT_CYCLES = 360_000;

    // Report frame: header, 24-bit average (MSB first), timeouts, mismatches.
    localparam int REPORT_LEN = 6;
    localparam int RPT_IDX_W  = 3;

    // Measurement/sequencing FSM in echo_timing_ctrl.
    typedef enum logic [3:0] {
        ST_IDLE,
        ST_PROBE,
        ST_TX_ACK,
        ST_TX_WAIT,
        ST_ECHO_WAIT,
        ST_NEXT_SAMPLE,
        ST_AVG,
        ST_REPORT,
        ST_FINISH
    } ctrl_state_t;

    // PC UART handshake FSM in echo_report_tx.
    typedef enum logic [1:0] {
        RPT_IDLE,
        RPT_SEND,
        RPT_ACK,
        RPT_WAIT
    } rpt_state_t;

    // Select one byte of the report frame by position.
    function automatic logic [7:0] frame_byte(
        input logic [RPT_IDX_W-1:0] idx,
        input logic [7:0]           hdr,
        input logic [23:0]          avg,
        input logic [7:0]           timeouts,
        input logic [7:0]           mismatches
    );
        logic [7:0] b;
        case (idx)
            3'd0:    b = hdr;
            3'd1:    b = avg[23:16];
            3'd2:    b = avg[15:8];
            3'd3:    b = avg[7:0];
            3'd4:    b = timeouts;
            3'd5:    b = mismatches;
            default: b = 8'h00;
        endcase
        return b;
    endfunction

    // 8-bit increment that sticks at 255 instead of wrapping.
    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction

endpackage

// File: rtl/echo_report_tx.sv
// Streams the 6-byte report frame to the PC UART, one strobe per byte,
// waiting for the UART to go idle between bytes. Pulses frame_done once
// the last byte has left the UART.
module echo_report_tx
    import uart_timing_pkg::*;
#(
    parameter int         CYC_W    = 20,
    parameter logic [7:0] HDR_BYTE = DEFAULT_HDR_BYTE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             go,
    input  logic [CYC_W-1:0] avg,
    input  logic [7:0]       timeouts,
    input  logic [7:0]       mismatches,
    input  logic             pc_tx_busy,
    output logic             pc_tx_start,
    output logic [7:0]       pc_tx_byte,
    output logic             frame_done
);

    localparam logic [RPT_IDX_W-1:0] LAST_IDX = RPT_IDX_W'(REPORT_LEN - 1);

    rpt_state_t           state;
    logic [RPT_IDX_W-1:0] byte_idx;
    logic [23:0]          avg_ext;

    // The average goes out as a 24-bit big-endian field.
    assign avg_ext = 24'(avg);

    // Strobe/ack/wait handshake; the byte register only changes when a new
    // strobe is issued, so it is stable for the whole transmit window.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= RPT_IDLE;
            byte_idx    <= '0;
            pc_tx_start <= 1'b0;
            pc_tx_byte  <= 8'h00;
            frame_done  <= 1'b0;
        end else begin
            pc_tx_start <= 1'b0;
            frame_done  <= 1'b0;
            case (state)
                RPT_IDLE: begin
                    if (go) begin
                        byte_idx <= '0;
                        state    <= RPT_SEND;
                    end
                end
                RPT_SEND: begin
                    if (!pc_tx_busy) begin
                        pc_tx_byte  <= frame_byte(byte_idx, HDR_BYTE, avg_ext,
                                                  timeouts, mismatches);
                        pc_tx_start <= 1'b1;
                        state       <= RPT_ACK;
                    end
                end
                // UART raises busy a cycle after the strobe; skip that cycle.
                RPT_ACK: begin
                    state <= RPT_WAIT;
                end
                RPT_WAIT: begin
                    if (!pc_tx_busy) begin
                        if (byte_idx == LAST_IDX) begin
                            frame_done <= 1'b1;
                            state      <= RPT_IDLE;
                        end else begin
                            byte_idx <= byte_idx + 3'd1;
                            state    <= RPT_SEND;
                        end
                    end
                end
                default: state <= RPT_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/echo_timing_ctrl.sv
// Round-trip echo timing controller. Sends 2**LOG2_SAMPLES probe bytes
// through the echo UART, times each echo (with a timeout), averages the
// samples with a shift and hands the result to echo_report_tx for the PC.
module echo_timing_ctrl
    import uart_timing_pkg::*;
#(
    parameter int         LOG2_SAMPLES   = 4,
    parameter int         TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
    parameter logic [7:0] PROBE_BYTE     = DEFAULT_PROBE_BYTE,
    parameter int         CYC_W          = 20,
    parameter logic [7:0] HDR_BYTE       = DEFAULT_HDR_BYTE
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    output logic             echo_tx_start,
    output logic [7:0]       echo_tx_byte,
    input  logic             echo_tx_busy,
    input  logic             echo_rx_valid,
    input  logic [7:0]       echo_rx_byte,
    output logic             pc_tx_start,
    output logic [7:0]       pc_tx_byte,
    input  logic             pc_tx_busy,
    output logic             busy,
    output logic             done,
    output logic [CYC_W-1:0] avg_cycles,
    output logic [7:0]       timeouts,
    output logic [7:0]       mismatches
);

    localparam int                  NUM_SAMPLES = 1 << LOG2_SAMPLES;
    localparam int                  ACC_W       = CYC_W + LOG2_SAMPLES;
    localparam int                  SIDX_W      = LOG2_SAMPLES + 1;
    localparam logic [CYC_W-1:0]    TIMEOUT_VAL = CYC_W'(TIMEOUT_CYCLES);
    localparam logic [SIDX_W-1:0]   LAST_SAMPLE = SIDX_W'(NUM_SAMPLES - 1);

    ctrl_state_t       state;
    logic [CYC_W-1:0]  cyc_cnt;
    logic [ACC_W-1:0]  acc;
    logic [SIDX_W-1:0] sample_idx;
    logic [7:0]        timeout_cnt;
    logic [7:0]        mismatch_cnt;
    logic              rpt_go;
    logic              frame_done;

    logic              sample_end;
    logic [CYC_W-1:0]  sample_val;
    logic              sample_timeout;
    logic              sample_mismatch;

    // Decide whether the current sample ends this cycle and with what value.
    // A reply arriving on the timeout cycle wins over the timeout.
    always_comb begin
        sample_end      = 1'b0;
        sample_val      = '0;
        sample_timeout  = 1'b0;
        sample_mismatch = 1'b0;
        if (state == ST_ECHO_WAIT) begin
            if (echo_rx_valid) begin
                sample_end      = 1'b1;
                sample_val      = (cyc_cnt > TIMEOUT_VAL) ? TIMEOUT_VAL : cyc_cnt;
                sample_mismatch = (echo_rx_byte != PROBE_BYTE);
            end else if (cyc_cnt >= TIMEOUT_VAL) begin
                sample_end     = 1'b1;
                sample_val     = TIMEOUT_VAL;
                sample_timeout = 1'b1;
            end
        end
    end

    // Measurement FSM with cycle counter, accumulator and published results.
    // Strobes are registered on entry to the state that owns them, so
    // echo_tx_start is high exactly during the PROBE cycle (cyc_cnt == 0).
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= ST_IDLE;
            cyc_cnt       <= '0;
            acc           <= '0;
            sample_idx    <= '0;
            timeout_cnt   <= 8'h00;
            mismatch_cnt  <= 8'h00;
            rpt_go        <= 1'b0;
            echo_tx_start <= 1'b0;
            echo_tx_byte  <= 8'h00;
            busy          <= 1'b0;
            done          <= 1'b0;
            avg_cycles    <= '0;
            timeouts      <= 8'h00;
            mismatches    <= 8'h00;
        end else begin
            echo_tx_start <= 1'b0;
            done          <= 1'b0;
            rpt_go        <= 1'b0;
            if (state != ST_IDLE && cyc_cnt != '1) begin
                cyc_cnt <= cyc_cnt + CYC_W'(1);
            end
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        acc           <= '0;
                        sample_idx    <= '0;
                        timeout_cnt   <= 8'h00;
                        mismatch_cnt  <= 8'h00;
                        echo_tx_byte  <= PROBE_BYTE;
                        echo_tx_start <= 1'b1;
                        cyc_cnt       <= '0;
                        busy          <= 1'b1;
                        state         <= ST_PROBE;
                    end
                end
                ST_PROBE: begin
                    state <= ST_TX_ACK;
                end
                // Echo UART raises busy one cycle after the strobe.
                ST_TX_ACK: begin
                    state <= ST_TX_WAIT;
                end
                ST_TX_WAIT: begin
                    if (!echo_tx_busy) begin
                        state <= ST_ECHO_WAIT;
                    end
                end
                ST_ECHO_WAIT: begin
                    if (sample_end) begin
                        acc        <= acc + ACC_W'(sample_val);
                        sample_idx <= sample_idx + SIDX_W'(1);
                        if (sample_timeout) begin
                            timeout_cnt <= sat_inc8(timeout_cnt);
                        end
                        if (sample_mismatch) begin
                            mismatch_cnt <= sat_inc8(mismatch_cnt);
                        end
                        state <= (sample_idx == LAST_SAMPLE) ? ST_AVG : ST_NEXT_SAMPLE;
                    end
                end
                ST_NEXT_SAMPLE: begin
                    echo_tx_start <= 1'b1;
                    cyc_cnt       <= '0;
                    state         <= ST_PROBE;
                end
                // Power-of-two sample count: the average is a plain shift.
                ST_AVG: begin
                    avg_cycles <= CYC_W'(acc >> LOG2_SAMPLES);
                    timeouts   <= timeout_cnt;
                    mismatches <= mismatch_cnt;
                    rpt_go     <= 1'b1;
                    state      <= ST_REPORT;
                end
                ST_REPORT: begin
                    if (frame_done) begin
                        done  <= 1'b1;
                        state <= ST_FINISH;
                    end
                end
                ST_FINISH: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: begin
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
            endcase
        end
    end

    echo_report_tx #(
        .CYC_W    (CYC_W),
        .HDR_BYTE (HDR_BYTE)
    ) u_report (
        .clk         (clk),
        .rst_n       (rst_n),
        .go          (rpt_go),
        .avg         (avg_cycles),
        .timeouts    (timeouts),
        .mismatches  (mismatches),
        .pc_tx_busy  (pc_tx_busy),
        .pc_tx_start (pc_tx_start),
        .pc_tx_byte  (pc_tx_byte),
        .frame_done  (frame_done)
    );

endmodule

// File: tb/tb_echo_timing_ctrl.sv
// Bench for echo_timing_ctrl: models both UARTs (busy rises one cycle
// after a strobe and lasts BUSY_LEN cycles), scripts echo replies per
// sample, and predicts average/timeouts/mismatches/frame from the rules.
module tb_echo_timing_ctrl;

    localparam int         LOG2_SAMPLES = 4;
    localparam int         NS           = 16;
    localparam int         TIMEOUT      = 600;
    localparam int         CYC_W        = 20;
    localparam int         BUSY_LEN     = 20;
    localparam int         DONE_BOUND   = 20000;
    localparam logic [7:0] PROBE        = 8'h56;
    localparam logic [7:0] HDR          = 8'hA5;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             start = 1'b0;
    logic             echo_tx_start;
    logic [7:0]       echo_tx_byte;
    logic             echo_tx_busy = 1'b0;
    logic             echo_rx_valid = 1'b0;
    logic [7:0]       echo_rx_byte = 8'h00;
    logic             pc_tx_start;
    logic [7:0]       pc_tx_byte;
    logic             pc_tx_busy = 1'b0;
    logic             busy;
    logic             done;
    logic [CYC_W-1:0] avg_cycles;
    logic [7:0]       timeouts;
    logic [7:0]       mismatches;

    int n_compared   = 0;
    int n_mismatched = 0;

    // per-sample echo script
    bit         reply_en   [NS];
    int         reply_dly  [NS];
    logic [7:0] reply_byte [NS];
    bit         stray_en   [NS];

    // model state
    int         cyc = 0;
    int         echo_strobes = 0;
    int         echo_byte_bad = 0;
    int         echo_busy_left = 0;
    int         echo_idx;
    int         pc_strobes = 0;
    int         pc_busy_left = 0;
    int         done_count = 0;
    int         tgt_cyc[$];
    logic [7:0] tgt_byte[$];
    logic [7:0] pc_bytes[$];

    echo_timing_ctrl #(
        .LOG2_SAMPLES   (LOG2_SAMPLES),
        .TIMEOUT_CYCLES (TIMEOUT),
        .PROBE_BYTE     (PROBE),
        .CYC_W          (CYC_W),
        .HDR_BYTE       (HDR)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start),
        .echo_tx_start (echo_tx_start),
        .echo_tx_byte  (echo_tx_byte),
        .echo_tx_busy  (echo_tx_busy),
        .echo_rx_valid (echo_rx_valid),
        .echo_rx_byte  (echo_rx_byte),
        .pc_tx_start   (pc_tx_start),
        .pc_tx_byte    (pc_tx_byte),
        .pc_tx_busy    (pc_tx_busy),
        .busy          (busy),
        .done          (done),
        .avg_cycles    (avg_cycles),
        .timeouts      (timeouts),
        .mismatches    (mismatches)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Echo UART model: busy window after each strobe, scripted replies.
    always @(negedge clk) begin
        echo_rx_valid = 1'b0;
        if (echo_busy_left > 0) begin
            echo_tx_busy = 1'b1;
            echo_busy_left--;
        end else begin
            echo_tx_busy = 1'b0;
        end
        for (int i = 0; i < tgt_cyc.size(); i++) begin
            if (tgt_cyc[i] == cyc) begin
                echo_rx_valid = 1'b1;
                echo_rx_byte  = tgt_byte[i];
                tgt_cyc.delete(i);
                tgt_byte.delete(i);
                break;
            end
        end
        if (echo_tx_start === 1'b1) begin
            echo_idx = echo_strobes % NS;
            if (echo_tx_byte !== PROBE) echo_byte_bad++;
            echo_busy_left = BUSY_LEN;
            if (stray_en[echo_idx]) begin
                tgt_cyc.push_back(cyc + 5);
                tgt_byte.push_back(8'h57);
            end
            if (reply_en[echo_idx]) begin
                tgt_cyc.push_back(cyc + reply_dly[echo_idx]);
                tgt_byte.push_back(reply_byte[echo_idx]);
            end
            echo_strobes++;
        end
    end

    // PC UART model plus done-pulse counter.
    always @(negedge clk) begin
        if (pc_busy_left > 0) begin
            pc_tx_busy = 1'b1;
            pc_busy_left--;
        end else begin
            pc_tx_busy = 1'b0;
        end
        if (pc_tx_start === 1'b1) begin
            pc_bytes.push_back(pc_tx_byte);
            pc_strobes++;
            pc_busy_left = BUSY_LEN;
        end
        if (done === 1'b1) done_count++;
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_compared++;
        assert (obs === exp) else begin
            n_mismatched++;
            $display("FAIL %s observed=%0d (0x%0h) expected=%0d (0x%0h)", tag, obs, obs, exp, exp);
            $error("check %s differs", tag);
        end
    endtask

    task automatic clear_models();
        echo_strobes  = 0;
        echo_byte_bad = 0;
        pc_strobes    = 0;
        done_count    = 0;
        pc_bytes.delete();
        tgt_cyc.delete();
        tgt_byte.delete();
    endtask

    task automatic script_all(input bit en, input int dly, input logic [7:0] b);
        for (int i = 0; i < NS; i++) begin
            reply_en[i]   = en;
            reply_dly[i]  = dly;
            reply_byte[i] = b;
            stray_en[i]   = 1'b0;
        end
    endtask

    // One measurement run: predict, start, wait for done, compare.
    task automatic run_and_check(input string tag, input bit extra_starts);
        int         sum = 0;
        int         exp_to = 0;
        int         exp_mm = 0;
        int         exp_avg;
        logic [7:0] exp_frame [6];
        logic [31:0] got;
        for (int i = 0; i < NS; i++) begin
            if (reply_en[i] && reply_dly[i] <= TIMEOUT) begin
                sum += reply_dly[i];
                if (reply_byte[i] != PROBE) exp_mm++;
            end else begin
                sum += TIMEOUT;
                exp_to++;
            end
        end
        exp_avg = sum / NS;
        exp_frame[0] = HDR;
        exp_frame[1] = 8'((exp_avg >> 16) & 255);
        exp_frame[2] = 8'((exp_avg >> 8) & 255);
        exp_frame[3] = 8'(exp_avg & 255);
        exp_frame[4] = 8'(exp_to);
        exp_frame[5] = 8'(exp_mm);

        clear_models();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        for (int n = 0; n < DONE_BOUND && done_count == 0; n++) begin
            @(negedge clk);
            start = (extra_starts && (n == 700 || n == 2500)) ? 1'b1 : 1'b0;
        end
        start = 1'b0;
        repeat (BUSY_LEN + 5) @(negedge clk);

        chk({tag, ".done_pulses"},  done_count, 1);
        chk({tag, ".echo_strobes"}, echo_strobes, NS);
        chk({tag, ".echo_byte"},    echo_byte_bad, 0);
        chk({tag, ".avg"},          32'(avg_cycles), exp_avg);
        chk({tag, ".timeouts"},     32'(timeouts), exp_to);
        chk({tag, ".mismatches"},   32'(mismatches), exp_mm);
        chk({tag, ".frame_len"},    pc_bytes.size(), 6);
        for (int k = 0; k < 6; k++) begin
            got = (k < pc_bytes.size()) ? 32'(pc_bytes[k]) : 32'hFFFF_FFFF;
            chk($sformatf("%s.frame%0d", tag, k), got, 32'(exp_frame[k]));
        end
        chk({tag, ".busy_after"},   32'(busy), 0);
        $display("run %s: avg=%0d timeouts=%0d mismatches=%0d frame_bytes=%0d (expect avg=%0d to=%0d mm=%0d)",
                 tag, avg_cycles, timeouts, mismatches, pc_bytes.size(), exp_avg, exp_to, exp_mm);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int saved;
        bit reached;
        script_all(1'b1, 200, PROBE);

        // reset state
        repeat (3) @(negedge clk);
        chk("reset.busy",       32'(busy), 0);
        chk("reset.done",       32'(done), 0);
        chk("reset.avg",        32'(avg_cycles), 0);
        chk("reset.timeouts",   32'(timeouts), 0);
        chk("reset.mismatches", 32'(mismatches), 0);
        chk("reset.echo_start", 32'(echo_tx_start), 0);
        chk("reset.pc_start",   32'(pc_tx_start), 0);
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // 1: all replies 'V' at 200 cycles
        script_all(1'b1, 200, PROBE);
        run_and_check("t1_steady", 1'b0);

        // 2: silent echo, every sample times out
        script_all(1'b0, 200, PROBE);
        run_and_check("t2_silent", 1'b0);

        // 3: alternating 'V'@150 / 'W'@250
        script_all(1'b1, 200, PROBE);
        for (int i = 0; i < NS; i++) begin
            reply_dly[i]  = (i % 2 == 0) ? 150 : 250;
            reply_byte[i] = (i % 2 == 0) ? PROBE : 8'h57;
        end
        run_and_check("t3_alternate", 1'b0);

        // 4: reply exactly on the timeout cycle counts as a reply
        script_all(1'b1, 200, PROBE);
        reply_dly[0] = TIMEOUT;
        run_and_check("t4_edge_reply", 1'b0);

        // 4b: reply one cycle past the timeout is a timeout (late echo discarded)
        script_all(1'b1, 200, PROBE);
        reply_dly[0] = TIMEOUT + 1;
        run_and_check("t4b_late_reply", 1'b0);

        // 5: start pulses mid-run and a stray rx_valid during TX_WAIT
        script_all(1'b1, 200, PROBE);
        stray_en[3] = 1'b1;
        run_and_check("t5_ignored", 1'b1);

        // random runs
        for (int r = 0; r < 2; r++) begin
            for (int i = 0; i < NS; i++) begin
                reply_en[i]   = ($urandom_range(0, 4) != 0);
                reply_dly[i]  = $urandom_range(30, TIMEOUT + 20);
                reply_byte[i] = ($urandom_range(0, 2) == 0) ? 8'($urandom_range(0, 255)) : PROBE;
                stray_en[i]   = 1'b0;
            end
            run_and_check($sformatf("rand%0d", r), 1'b0);
        end

        // 6: reset during the wait after report byte 3
        script_all(1'b1, 200, PROBE);
        clear_models();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        reached = 1'b0;
        for (int n = 0; n < DONE_BOUND; n++) begin
            @(negedge clk);
            if (pc_strobes >= 4) begin
                reached = 1'b1;
                break;
            end
        end
        chk("t6.reached_byte3", 32'(reached), 1);
        repeat (3) @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("t6.avg",        32'(avg_cycles), 0);
        chk("t6.timeouts",   32'(timeouts), 0);
        chk("t6.mismatches", 32'(mismatches), 0);
        chk("t6.busy",       32'(busy), 0);
        chk("t6.done",       32'(done), 0);
        chk("t6.pc_byte",    32'(pc_tx_byte), 0);
        chk("t6.echo_byte",  32'(echo_tx_byte), 0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        saved = pc_strobes;
        repeat (300) @(negedge clk);
        chk("t6.no_more_pc", pc_strobes, saved);
        chk("t6.no_done",    done_count, 0);
        chk("t6.idle_busy",  32'(busy), 0);
        $display("run t6_reset: pc strobes before reset=%0d after=%0d", saved, pc_strobes);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
